// File: rtl/conv_window_addr_gen.sv
// conv_window_addr_gen: produces one 3x3 convolution window per cycle.
// Scan order is stride 1 with "same" padding and the input channel innermost.
// Taps that fall outside the feature map have their read enable cleared and
// their address forced to 0.
module conv_window_addr_gen #(
    parameter int width    = 80,
    parameter int height   = 8,
    parameter int width_b  = 7,
    parameter int height_b = 3,
    parameter int ch_b     = 4,
    localparam int AW      = height_b + width_b
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ch_b-1:0]     n_ch,
    input  logic                hold,
    output logic [9*AW-1:0]     addr,
    output logic [8:0]          en_read,
    output logic                en_bias,
    output logic [ch_b-1:0]     ch,
    output logic [height_b-1:0] row,
    output logic [width_b-1:0]  col,
    output logic                valid,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [height_b-1:0] ROW_LAST = height_b'(height - 1);
    localparam logic [width_b-1:0]  COL_LAST = width_b'(width - 1);

    state_t              state_q, state_d;
    logic [height_b-1:0] r_q, r_d;
    logic [width_b-1:0]  c_q, c_d;
    logic [ch_b-1:0]     k_q, k_d;
    logic [ch_b-1:0]     nch_q, nch_d;

    logic [9*AW-1:0]     addr_q, addr_d;
    logic [8:0]          en_read_q, en_read_d;
    logic                en_bias_q, en_bias_d;
    logic [ch_b-1:0]     ch_q, ch_d;
    logic [height_b-1:0] row_q, row_d;
    logic [width_b-1:0]  col_q, col_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Window for the current counters, computed combinationally per tap.
    logic [9*AW-1:0]     win_addr;
    logic [8:0]          win_en;

    // Tap t = 3*i + j sits at (r+i-1, c+j-1); the i=0/j=0 taps are off-map on
    // the first row/column and the i=2/j=2 taps on the last row/column.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_tap
            localparam int TI = gi / 3;
            localparam int TJ = gi % 3;
            logic [height_b-1:0] tap_r;
            logic [width_b-1:0]  tap_c;
            logic                row_ok;
            logic                col_ok;

            assign tap_r  = r_q + height_b'(TI) - height_b'(1);
            assign tap_c  = c_q + width_b'(TJ) - width_b'(1);
            assign row_ok = (TI == 0) ? (r_q != '0) :
                            (TI == 2) ? (r_q != ROW_LAST) : 1'b1;
            assign col_ok = (TJ == 0) ? (c_q != '0) :
                            (TJ == 2) ? (c_q != COL_LAST) : 1'b1;
            assign win_en[8-gi] = row_ok && col_ok;
            assign win_addr[(9-gi)*AW-1 -: AW] = win_en[8-gi] ? {tap_r, tap_c} : '0;
        end
    endgenerate

    // Next-state, counter advance and registered-output computation.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        k_d       = k_q;
        nch_d     = nch_q;
        addr_d    = addr_q;
        ch_d      = ch_q;
        row_d     = row_q;
        col_d     = col_q;
        en_read_d = '0;
        en_bias_d = 1'b0;
        valid_d   = 1'b0;
        // done appears on the cycle after the DONE state is entered
        done_d    = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nch_d   = (n_ch == '0) ? ch_b'(1) : n_ch;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    valid_d   = 1'b1;
                    addr_d    = win_addr;
                    en_read_d = win_en;
                    en_bias_d = (k_q == '0);
                    ch_d      = k_q;
                    row_d     = r_q;
                    col_d     = c_q;
                    if (k_q == nch_q - ch_b'(1)) begin
                        k_d = '0;
                        if (c_q == COL_LAST) begin
                            c_d = '0;
                            if (r_q == ROW_LAST) begin
                                r_d     = '0;
                                state_d = S_DONE;
                            end else begin
                                r_d = r_q + height_b'(1);
                            end
                        end else begin
                            c_d = c_q + width_b'(1);
                        end
                    end else begin
                        k_d = k_q + ch_b'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy covers the scan plus the cycle on which done is shown
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            nch_q     <= '0;
            addr_q    <= '0;
            en_read_q <= '0;
            en_bias_q <= 1'b0;
            ch_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            k_q       <= k_d;
            nch_q     <= nch_d;
            addr_q    <= addr_d;
            en_read_q <= en_read_d;
            en_bias_q <= en_bias_d;
            ch_q      <= ch_d;
            row_q     <= row_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign addr    = addr_q;
    assign en_read = en_read_q;
    assign en_bias = en_bias_q;
    assign ch      = ch_q;
    assign row     = row_q;
    assign col     = col_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Testbench for conv_window_addr_gen on a 4x3 map: expected windows are queued
// per scan and a negedge monitor pops and compares each issued window, while
// the main process checks timing, stalls, reset and start handling.
module tb_conv_window_addr_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int WB = 2;
    localparam int HB = 2;
    localparam int CB = 4;
    localparam int AW = HB + WB;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CB-1:0]     n_ch;
    logic              hold;
    logic [9*AW-1:0]   addr;
    logic [8:0]        en_read;
    logic              en_bias;
    logic [CB-1:0]     ch;
    logic [HB-1:0]     row;
    logic [WB-1:0]     col;
    logic              valid;
    logic              busy;
    logic              done;

    conv_window_addr_gen #(
        .width(W), .height(H), .width_b(WB), .height_b(HB), .ch_b(CB)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .n_ch(n_ch), .hold(hold),
        .addr(addr), .en_read(en_read), .en_bias(en_bias), .ch(ch),
        .row(row), .col(col), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9*AW-1:0] addr;
        logic [8:0]      en;
        logic            bias;
        logic [CB-1:0]   ch;
        logic [HB-1:0]   row;
        logic [WB-1:0]   col;
    } win_t;

    win_t exp_q[$];
    win_t exp_w;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference window from signed tap coordinates.
    function automatic win_t model(input int r, input int c, input int k);
        win_t w;
        w      = '0;
        w.row  = HB'(r);
        w.col  = WB'(c);
        w.ch   = CB'(k);
        w.bias = (k == 0);
        for (int t = 0; t < 9; t++) begin
            int tr;
            int tc;
            tr = r + t / 3 - 1;
            tc = c + t % 3 - 1;
            if (tr >= 0 && tr < H && tc >= 0 && tc < W) begin
                w.en[8-t] = 1'b1;
                w.addr[(9-t)*AW-1 -: AW] = AW'(tr * (1 << WB) + tc);
            end
        end
        return w;
    endfunction

    task automatic push_scan(input int nch);
        int eff;
        eff = (nch == 0) ? 1 : nch;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int k = 0; k < eff; k++)
                    exp_q.push_back(model(r, c, k));
    endtask

    // Monitor: every issued window is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_window: got row %0d col %0d ch %0d, required no window",
                         row, col, ch);
            end else begin
                exp_w = exp_q.pop_front();
                check("win_row",     64'(row),     64'(exp_w.row));
                check("win_col",     64'(col),     64'(exp_w.col));
                check("win_ch",      64'(ch),      64'(exp_w.ch));
                check("win_en_bias", 64'(en_bias), 64'(exp_w.bias));
                check("win_en_read", 64'(en_read), 64'(exp_w.en));
                check("win_addr",    64'(addr),    64'(exp_w.addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int nch);
        n_ch  = CB'(nch);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Steps until done, counting windows and checking done/busy timing.
    task automatic run_to_done(input int exp_windows, input bit corners);
        int nv;
        int last;
        int first;
        int dcyc;
        int cyc;
        logic [9*AW-1:0] prev_addr;
        logic [8:0]      prev_en;
        nv = 0; last = -1; first = -1; dcyc = -1; cyc = 0;
        prev_addr = '0; prev_en = '0;
        while (dcyc < 0 && cyc < 2000) begin
            tick();
            cyc++;
            if (valid) begin
                nv++;
                last = cyc;
                if (first < 0) first = cyc;
                if (ch != '0) begin
                    check("ch_same_addr", 64'(addr), 64'(prev_addr));
                    check("ch_same_en",   64'(en_read), 64'(prev_en));
                end
                prev_addr = addr;
                prev_en   = en_read;
                if (corners) begin
                    if (row == 2'd0 && col == 2'd0 && ch == '0) begin
                        check("corner00_en",   64'(en_read), 64'h01B);
                        check("corner00_addr", 64'(addr),    64'h000001045);
                        check("corner00_bias", 64'(en_bias), 64'h1);
                    end
                    if (row == 2'd1 && col == 2'd1 && ch == '0) begin
                        check("interior_en",   64'(en_read), 64'h1FF);
                        check("interior_addr", 64'(addr),    64'h01245689A);
                    end
                    if (row == 2'd2 && col == 2'd3 && ch == '0)
                        check("corner23_en", 64'(en_read), 64'h1B0);
                end
            end
            if (done) dcyc = cyc;
        end
        if (corners) check("first_window_latency", 64'(first), 64'(1));
        check("window_count",    64'(nv),          64'(exp_windows));
        check("done_after_last", 64'(dcyc - last), 64'(1));
        check("busy_at_done",    64'(busy),        64'h1);
        tick();
        check("busy_fall",   64'(busy),         64'h0);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        n_ch  = CB'(1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",   64'(valid),   64'h0);
        check("rst_busy",    64'(busy),    64'h0);
        check("rst_done",    64'(done),    64'h0);
        check("rst_addr",    64'(addr),    64'h0);
        check("rst_en_read", 64'(en_read), 64'h0);
        check("rst_other",   64'({en_bias, ch, row, col}), 64'h0);
        reset = 1'b0;
        tick();

        // Corner/interior taps and scan length, single channel
        push_scan(1);
        do_start(1);
        check("busy_after_start",  64'(busy),  64'h1);
        check("valid_after_start", 64'(valid), 64'h0);
        run_to_done(12, 1'b1);

        // Channel loop
        push_scan(3);
        do_start(3);
        run_to_done(36, 1'b1);
        push_scan(0);
        do_start(0);
        run_to_done(12, 1'b0);

        // Two-edge stall after the 5th window
        push_scan(1);
        do_start(1);
        repeat (5) tick();
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("hold_valid",   64'(valid),   64'h0);
            check("hold_en_read", 64'(en_read), 64'h0);
            check("hold_en_bias", 64'(en_bias), 64'h0);
            check("hold_rowcol",  64'({row, col}), 64'({2'd1, 2'd0}));
        end
        hold = 1'b0;
        tick();
        check("resume_valid",  64'(valid),      64'h1);
        check("resume_rowcol", 64'({row, col}), 64'({2'd1, 2'd1}));
        run_to_done(6, 1'b0);

        // Stall on the final window delays done
        push_scan(1);
        do_start(1);
        repeat (11) tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("final_hold_valid", 64'(valid), 64'h0);
            check("final_hold_done",  64'(done),  64'h0);
        end
        hold = 1'b0;
        run_to_done(1, 1'b0);

        // Asynchronous reset mid-scan, then a full scan
        push_scan(1);
        do_start(1);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(valid), 64'h0);
        check("async_rst_busy",  64'(busy),  64'h0);
        check("async_rst_addr",  64'(addr),  64'h0);
        check("async_rst_col",   64'(col),   64'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        push_scan(1);
        do_start(1);
        run_to_done(12, 1'b1);

        // start while busy is ignored
        push_scan(1);
        do_start(1);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_done(8, 1'b0);

        // start held high: back-to-back scans
        begin
            int nv;
            int cyc;
            int ndone;
            int last1;
            int first2;
            int d1;
            nv = 0; cyc = 0; ndone = 0; last1 = -1; first2 = -1; d1 = -1;
            push_scan(1);
            push_scan(1);
            n_ch  = CB'(1);
            start = 1'b1;
            tick();
            while (ndone < 2 && cyc < 500) begin
                tick();
                cyc++;
                if (valid) begin
                    nv++;
                    if (nv == 12) last1 = cyc;
                    if (nv == 13) first2 = cyc;
                end
                if (done) begin
                    ndone++;
                    if (ndone == 1) d1 = cyc;
                    if (ndone == 2) start = 1'b0;
                end
            end
            start = 1'b0;
            check("b2b_windows",  64'(nv),             64'(24));
            check("b2b_done_gap", 64'(d1 - last1),     64'(1));
            check("b2b_restart",  64'(first2 - last1), 64'(3));
            tick();
            check("b2b_busy_fall", 64'(busy),         64'h0);
            check("b2b_queue",     64'(exp_q.size()), 64'(0));
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_window_addr_gen.md
# conv_window_addr_gen

Generates the per-cycle 3x3 convolution window for the PE array. For each output pixel it emits nine feature-map read addresses, the 9-bit zero-padding mask `en_read`, and the `en_bias` strobe. It sits directly upstream of the feature-map/bias memories and the control-part stage, which registers `en_read`/`en_bias` one cycle to line up with the memory read data. Scan order is stride 1 with "same" padding, input channel innermost.

## Interface
- `width`, 80, feature-map columns
- `height`, 8, feature-map rows
- `width_b`, 7, column index bits (must satisfy 2^width_b >= width)
- `height_b`, 3, row index bits (must satisfy 2^height_b >= height)
- `ch_b`, 4, channel count/index bits; AW = height_b+width_b
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a scan; sampled only in IDLE
- `n_ch`  in  ch_b  input channels per pixel; 0 is treated as 1; sampled at start
- `hold`  in  1  downstream stall; freezes the scan
- `addr`  out  9*AW  tap addresses {row,col}; tap t at `addr[(9-t)*AW-1 -: AW]`, tap 0 in the MSBs
- `en_read`  out  9  tap enable; tap t drives bit 8-t
- `en_bias`  out  1  high on channel 0 of every pixel
- `ch`  out  ch_b  channel index of the issued window
- `row`, `col`  out  height_b, width_b  output pixel coordinates
- `valid`  out  1  a window is issued this cycle
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse after the last window

## Operation
- **Reset:** all outputs are registered and reset to 0 (`addr`, `en_read`, `en_bias`, `ch`, `row`, `col`, `valid`, `busy`, `done`). The state returns to IDLE immediately on `reset`, including mid-scan. Scan counters clear to 0.
- **IDLE:** `start`=1 latches `n_ch` (0 becomes 1), clears counters (r, c, k) to 0, and moves to RUN. All other inputs are ignored.
- **RUN, `hold`=0:** each edge issues the window at the current counters, then advances them.
  - Advance order: k++ first. At k=n_ch-1, k wraps to 0 and c++. At c=width-1, c wraps to 0 and r++.
  - The edge that issues (height-1, width-1, n_ch-1) moves to DONE.
- **RUN, `hold`=1:** on that edge the counters and `addr`/`ch`/`row`/`col` are unchanged, and `valid`, `en_read`, `en_bias` register 0. The next issued window after release is the first not-yet-issued one: no window is skipped or duplicated.
- **DONE:** `done`=1 and `busy`=1 for one cycle, then IDLE. `start` and `hold` are ignored in DONE.
- `start` while `busy`=1 is ignored.
- **Issuing window (r,c,k):**
  - `valid`=1; `row`=r; `col`=c; `ch`=k; `en_bias`=(k==0).
  - For tap t=3i+j (i,j in 0..2): tr=r+i-1 and tc=c+j-1, evaluated in signed arithmetic one bit wider than the index.
  - If 0<=tr<height and 0<=tc<width: `en_read[8-t]`=1 and the tap address is {tr[height_b-1:0], tc[width_b-1:0]}.
  - Otherwise `en_read[8-t]`=0 and the tap address is 0.
- Windows per scan: height*width*max(n_ch,1).

## Timing
- `start` sampled high at edge E0 gives `busy`=1 after E0.
- The first window is issued at edge E1. With no holds, window n is issued at edge En.
- Last window at edge EL; `valid` is low and `done`/`busy` are high after EL+1; `busy` is 0 after EL+2.
- A new `start` is accepted from EL+2 (IDLE) onward.
- `hold` takes effect at the same edge it is sampled. There is zero-cycle latency from `hold` to `valid`=0 on the registered output.
- Downstream adds its own one-cycle enable delay; this block does not compensate for it.

## Test plan
Test parameters unless stated: width=4, height=3, width_b=2, height_b=2, n_ch=1.
1. **Corner taps:** pulse `start` -> window (0,0): `en_read`=9'h01B, `en_bias`=1, tap 4 addr=0, tap 8 addr=4'b0101, taps 0-3 and 6 addr=0. Window (2,3): `en_read`=9'h1B0.
2. **Interior window:** window (1,1) -> `en_read`=9'h1FF, tap 0 addr=4'b0000, tap 8 addr=4'b1010. Scan issues exactly 12 `valid` cycles, `done` pulses one cycle after the 12th, `busy` falls the following cycle.
3. **Channel loop:** n_ch=3 -> 36 windows; `ch` sequence 0,1,2 repeating; `en_bias` 1,0,0 repeating. `addr`/`en_read` are identical across the 3 channels of a pixel. n_ch=0 -> 12 windows.
4. **Stall:** `hold` high for 2 edges after the 5th window -> `valid`/`en_read`/`en_bias` are 0 on those 2 cycles and the 6th window is (1,1). Total is still 12 distinct windows. `hold` asserted on the final window edge delays `done` by the hold length.
5. **Reset and start handling:**
   - Assert `reset` mid-scan -> outputs go to 0 asynchronously; after release, `start` gives a full scan from (0,0).
   - `start` pulsed while `busy` -> ignored, window count unchanged.
   - `start` held high continuously -> back-to-back scans separated by exactly one DONE cycle and one IDLE cycle.
